// File: rtl/epack_pkg.sv
// epack_pkg: shared geometry for the element packer.
//   VLEN/BSW set the vector shape; BS lanes per vector, BLEN bits per lane.
//   lane_t is one element lane, cnt_t holds an occupancy count 0..2*BS.
package epack_pkg;
  localparam int VLEN = 256;
  localparam int BSW  = 5;
  localparam int BS   = 1 << BSW;
  localparam int BLEN = VLEN / BS;
  typedef logic [BLEN-1:0] lane_t;
  typedef logic [BSW+1:0]  cnt_t;
endpackage

// File: rtl/epack_shift.sv
// epack_shift: places BS input lanes at slot offset off of a 2*BS-slot vector.
//   en   : placement enabled (no write enables when low)
//   off  : first destination slot
//   num  : number of input lanes to place (0..BS)
//   data : input lanes
//   vec  : per-slot candidate data, valid where we is set
//   we   : per-slot write enables, slots off..off+num-1
module epack_shift
  import epack_pkg::*;
(
  input  logic                  en,
  input  cnt_t                  off,
  input  cnt_t                  num,
  input  lane_t [BS-1:0]        data,
  output lane_t [2*BS-1:0]      vec,
  output logic  [2*BS-1:0]      we
);
  for (genvar i = 0; i < 2*BS; i++) begin : g_slot
    cnt_t k;
    assign k = cnt_t'(i) - off;
    assign we[i] = en && cnt_t'(i) >= off && k < num;
    assign vec[i] = data[k[BSW-1:0]];
  end
endmodule

// File: rtl/epack.sv
// epack: compacts sparse element-pair beats into dense BS-lane output vectors.
//   clk, rst (async, active high)
//   in_valid/in_ready/in_num/in_data1/in_data2/in_last : input beats, lanes 0..in_num-1 valid
//   out_valid/out_ready/out_num/out_data1/out_data2/out_last : packed output vectors
//   stall_cnt : present only when EPACK_STALL_CNT_EN is defined; counts in_valid & !in_ready cycles
// Staging slots at and above cnt are always zero, so the output lanes beyond out_num read as zero
// without extra masking.
module epack
  import epack_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [BSW:0]   in_num,
  input  lane_t [BS-1:0] in_data1,
  input  lane_t [BS-1:0] in_data2,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [BSW:0]   out_num,
  output lane_t [BS-1:0] out_data1,
  output lane_t [BS-1:0] out_data2,
  output logic           out_last
`ifdef EPACK_STALL_CNT_EN
  ,
  output logic [31:0]    stall_cnt
`endif
);
  cnt_t cnt, cnt_p, sh, len;
  logic flushing, empty_last, pop, push;
  lane_t [2*BS-1:0] stage1, stage2, vec1, vec2, next1, next2;
  logic [2*BS-1:0] we1, we2;
  assign out_num   = cnt >= cnt_t'(BS) ? (BSW+1)'(BS) : cnt[BSW:0];
  assign out_valid = cnt >= cnt_t'(BS) || (flushing && cnt != '0) || empty_last;
  // While flushing no more input arrives, so a vector holding all remaining lanes is the last.
  assign out_last  = flushing && cnt <= cnt_t'(BS);
  assign pop       = out_valid && out_ready;
  assign sh        = pop ? cnt_t'(out_num) : '0;
  assign cnt_p     = cnt - sh;
  assign in_ready  = !flushing && cnt_p <= cnt_t'(BS);
  assign push      = in_valid && in_ready;
  assign len       = in_num > (BSW+1)'(BS) ? cnt_t'(BS) : cnt_t'(in_num);
  assign out_data1 = stage1[BS-1:0];
  assign out_data2 = stage2[BS-1:0];
  epack_shift u_shift1 (.en(push), .off(cnt_p), .num(len), .data(in_data1), .vec(vec1), .we(we1));
  epack_shift u_shift2 (.en(push), .off(cnt_p), .num(len), .data(in_data2), .vec(vec2), .we(we2));
  // Pop shifts the staging buffer down by sh lanes, then the new beat lands at cnt_p.
  for (genvar i = 0; i < 2*BS; i++) begin : g_lane
    cnt_t idx;
    assign idx = cnt_t'(i) + sh;
    assign next1[i] = we1[i] ? vec1[i] : idx < cnt_t'(2*BS) ? stage1[idx[BSW:0]] : '0;
    assign next2[i] = we2[i] ? vec2[i] : idx < cnt_t'(2*BS) ? stage2[idx[BSW:0]] : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt        <= '0;
      flushing   <= 1'b0;
      empty_last <= 1'b0;
      stage1     <= '0;
      stage2     <= '0;
    end else begin
      cnt    <= cnt_p + (push ? len : '0);
      stage1 <= next1;
      stage2 <= next2;
      if (push && in_last) begin
        flushing   <= 1'b1;
        empty_last <= (cnt_p + len) == '0;
      end else if (pop && out_last) begin
        flushing   <= 1'b0;
        empty_last <= 1'b0;
      end
    end
`ifdef EPACK_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt <= '0;
    else if (in_valid && !in_ready && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_epack.sv
// tb_epack: randomized self-checking bench for epack against a lane-queue reference model.
module tb_epack;
  import epack_pkg::*;
  typedef lane_t [BS-1:0] vec_t;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [BSW:0] in_num, out_num;
  vec_t in_data1, in_data2, out_data1, out_data2;
`ifdef EPACK_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  int checks = 0;
  int errors = 0;
  lane_t q1[$], q2[$];
  bit fl, el, exp_rdy, dut_rdy;
  int stalls;

  epack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num),
    .in_data1(in_data1), .in_data2(in_data2), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_num(out_num), .out_data1(out_data1), .out_data2(out_data2),
    .out_last(out_last)
`ifdef EPACK_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic int m_num();
    return q1.size() > BS ? BS : q1.size();
  endfunction
  function automatic bit m_valid();
    return q1.size() >= BS || (fl && q1.size() > 0) || el;
  endfunction
  function automatic bit m_last();
    return fl && q1.size() <= BS;
  endfunction
  function automatic vec_t m_data(bit sel);
    vec_t v = '0;
    for (int k = 0; k < m_num(); k++) v[k] = sel ? q2[k] : q1[k];
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_num = '0; in_last = 1'b0; out_ready = 1'b0;
    in_data1 = '0; in_data2 = '0;
    q1.delete(); q2.delete(); fl = 0; el = 0; stalls = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock: drive a beat, advance the model by the cycle's pop then append, step the clock.
  task automatic step(input bit iv, input int n, input bit last, input bit ordy);
    int nn;
    bit pop;
    in_valid = iv; in_num = n[BSW:0]; in_last = last; out_ready = ordy;
    for (int k = 0; k < BS; k++) begin
      in_data1[k] = lane_t'($urandom);
      in_data2[k] = lane_t'($urandom);
    end
    #1;
    dut_rdy = in_ready;
    pop = m_valid() && ordy;
    nn = m_num();
    if (pop) repeat (nn) begin void'(q1.pop_front()); void'(q2.pop_front()); end
    exp_rdy = !fl && q1.size() <= BS;
    if (pop && fl && q1.size() == 0) begin fl = 0; el = 0; end
    if (iv && !exp_rdy) stalls++;
    if (iv && exp_rdy) begin
      nn = n > BS ? BS : n;
      for (int k = 0; k < nn; k++) begin q1.push_back(in_data1[k]); q2.push_back(in_data2[k]); end
      if (last) begin fl = 1; el = q1.size() == 0; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_num !== '0) begin errors++; $display("FAIL reset_num: got %0d expected 0", out_num); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", out_last); end
    checks++; if (out_data1 !== '0 || out_data2 !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data1); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_fill();
    do_reset();
    step(1, 20, 0, 1);
    checks++; if (out_valid !== 1'b0 || out_num !== 6'd20) begin errors++; $display("FAIL fill_b1: got valid %b num %0d expected 0/20", out_valid, out_num); end
    step(1, 20, 0, 1);
    checks++; if (out_valid !== 1'b1 || out_num !== 6'd32) begin errors++; $display("FAIL fill_b2: got valid %b num %0d expected 1/32", out_valid, out_num); end
    checks++; if (out_data1 !== m_data(0) || out_data2 !== m_data(1)) begin errors++; $display("FAIL fill_data: got %h expected %h", out_data1, m_data(0)); end
    step(1, 20, 0, 1);
    checks++; if (out_valid !== 1'b0 || out_num !== 6'd28) begin errors++; $display("FAIL fill_b3: got valid %b num %0d expected 0/28", out_valid, out_num); end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(1, 32, 0, 0);
    step(1, 32, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_num !== 6'd32) begin errors++; $display("FAIL bp_full: got valid %b num %0d expected 1/32", out_valid, out_num); end
    step(1, 32, 0, 0);
    checks++; if (dut_rdy !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", dut_rdy); end
    for (int c = 0; c < 24; c++) begin
      step(c < 20, 32, 0, 1);
      checks++; if (dut_rdy !== exp_rdy) begin errors++; $display("FAIL bp_rdy%0d: got %b expected %b", c, dut_rdy, exp_rdy); end
      checks++; if (out_valid !== m_valid() || out_num !== 6'(m_num())) begin errors++; $display("FAIL bp_vn%0d: got %b/%0d expected %b/%0d", c, out_valid, out_num, m_valid(), m_num()); end
      checks++; if (out_data1 !== m_data(0) || out_data2 !== m_data(1)) begin errors++; $display("FAIL bp_data%0d: got %h expected %h", c, out_data1, m_data(0)); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    step(1, 10, 0, 0);
    step(1, 5, 1, 0);
    checks++; if (out_valid !== 1'b1 || out_num !== 6'd15 || out_last !== 1'b1) begin errors++; $display("FAIL flush_vec: got %b/%0d/%b expected 1/15/1", out_valid, out_num, out_last); end
    checks++; if (out_data1 !== m_data(0) || out_data2 !== m_data(1)) begin errors++; $display("FAIL flush_data: got %h expected %h", out_data1, m_data(0)); end
    step(1, 7, 0, 0);
    checks++; if (dut_rdy !== 1'b0) begin errors++; $display("FAIL flush_blocked: got %b expected 0", dut_rdy); end
    step(0, 0, 0, 1);
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL flush_done: got %b/%b expected 0/0", out_valid, out_last); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_empty_last();
    do_reset();
    step(1, 0, 0, 1);
    checks++; if (out_valid !== 1'b0 || out_num !== 6'd0) begin errors++; $display("FAIL zero_beat: got %b/%0d expected 0/0", out_valid, out_num); end
    step(1, 0, 1, 0);
    checks++; if (out_valid !== 1'b1 || out_num !== 6'd0 || out_last !== 1'b1) begin errors++; $display("FAIL empty_last: got %b/%0d/%b expected 1/0/1", out_valid, out_num, out_last); end
    step(0, 0, 0, 1);
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL empty_done: got %b/%b expected 0/0", out_valid, out_last); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1, 32, 0, 0);
    step(1, 8, 0, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_valid: got %b expected 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_num !== '0 || out_data1 !== '0 || out_last !== 1'b0) begin errors++; $display("FAIL mid_rst: got %b/%0d/%h expected zeros", out_valid, out_num, out_data1); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", in_ready); end
    do_reset();
    step(0, 0, 0, 0);
    checks++; if (out_num !== '0) begin errors++; $display("FAIL mid_cnt: got %0d expected 0", out_num); end
  endtask

  task automatic test_clamp();
    do_reset();
    step(1, 63, 0, 0);
    checks++; if (out_num !== 6'd32 || out_data1 !== m_data(0)) begin errors++; $display("FAIL clamp: got %0d expected 32", out_num); end
    step(1, 32, 0, 0);
    repeat (7) step(1, 5, 0, 0);
    checks++; if (out_num !== 6'd32 || dut_rdy !== 1'b0) begin errors++; $display("FAIL clamp_full: got %0d/%b expected 32/0", out_num, dut_rdy); end
`ifdef EPACK_STALL_CNT_EN
    checks++; if (stall_cnt !== 32'd7) begin errors++; $display("FAIL stall_cnt: got %0d expected 7", stall_cnt); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 40), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
      checks++; if (dut_rdy !== exp_rdy) begin errors++; $display("FAIL rnd_rdy%0d: got %b expected %b", c, dut_rdy, exp_rdy); end
      checks++; if (out_valid !== m_valid() || out_num !== 6'(m_num()) || out_last !== m_last()) begin errors++; $display("FAIL rnd_ctl%0d: got %b/%0d/%b expected %b/%0d/%b", c, out_valid, out_num, out_last, m_valid(), m_num(), m_last()); end
      checks++; if (out_data1 !== m_data(0) || out_data2 !== m_data(1)) begin errors++; $display("FAIL rnd_data%0d: got %h expected %h", c, out_data1, m_data(0)); end
    end
`ifdef EPACK_STALL_CNT_EN
    checks++; if (stall_cnt !== 32'(stalls)) begin errors++; $display("FAIL rnd_stall: got %0d expected %0d", stall_cnt, stalls); end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_backpressure();
    test_flush();
    test_empty_last();
    test_reset_mid();
    test_clamp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
